// File: rtl/ahb_slave_interface.sv
// ---------------------------------------------------------------------------
// ahb_slave_interface
//
// AHB slave that serves single-word reads and writes from an internal
// register file. The slave samples the address phase when it is selected. It
// then inserts WAIT_STATES wait cycles and completes the data phase. An
// address outside the register file gets the two-cycle ERROR response.
//
// Parameters
//   ADDR_BITS   : register file depth is 2**ADDR_BITS 32-bit words
//   WAIT_STATES : wait cycles per OKAY transfer (0..15)
//
// Ports
//   hclk     in   bus clock
//   hresetn  in   asynchronous active-low reset
//   hsel     in   slave select from the decoder
//   haddr    in   [31:0] byte address
//   hwrite   in   1 = write, 0 = read
//   htrans   in   [1:0] IDLE/BUSY/NONSEQ/SEQ
//   hwdata   in   [31:0] write data (data phase)
//   hrdata   out  [31:0] read data (registered)
//   hready   out  data phase completes this cycle (registered)
//   hresp    out  [1:0] OKAY / ERROR (registered)
// ---------------------------------------------------------------------------
module ahb_slave_interface #(
  parameter int ADDR_BITS   = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic [1:0]  hresp
);

  localparam int          DEPTH      = 1 << ADDR_BITS;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_ERROR = 2'b01;
  localparam logic [3:0]  WAIT_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                 state;
  logic [3:0]             wait_cnt;
  logic [ADDR_BITS-1:0]   cur_index;
  logic                   cur_write;
  logic [31:0]            mem [DEPTH];

  logic                   accept;
  logic                   in_range;
  logic                   commit;
  logic [ADDR_BITS-1:0]   new_index;
  logic [31:0]            rd_data;

  // Byte-lane bits and the SEQ/NONSEQ distinction carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{haddr[1:0], htrans[0]};

  // hready is the registered "this is a completing cycle" flag, so it also
  // tells us whether the master may present a new address phase now.
  assign accept    = hready && hsel && htrans[1];
  assign in_range  = (haddr[31:ADDR_BITS+2] == '0);
  assign new_index = haddr[ADDR_BITS+1:2];
  assign commit    = (state == S_DATA) && cur_write;

  // Read data for a read entering DATA straight from the address phase. A
  // write to the same word that commits on this edge wins over the array.
  always_comb begin
    // NOTE: default assignment first so no path leaves rd_data unassigned (no latch).
    rd_data = mem[new_index];
    if (commit && (cur_index == new_index)) begin
      rd_data = hwdata;
    end
  end

  // Register file
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      // NOTE: the array is reset explicitly because reset must clear every word; this keeps it in flops, not RAM.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      mem[cur_index] <= hwdata;
    end
  end

  // Transfer FSM with registered bus outputs
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      cur_index <= '0;
      cur_write <= 1'b0;
      hready    <= 1'b1;
      hresp     <= RESP_OKAY;
      hrdata    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DATA, S_ERR2: begin
          if (accept) begin
            // NOTE: non-blocking updates let the outgoing transfer commit from the old cur_* while the new one is captured.
            cur_index <= new_index;
            cur_write <= hwrite;
            if (!in_range) begin
              state  <= S_ERR1;
              hready <= 1'b0;
              hresp  <= RESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
              hready   <= 1'b0;
              hresp    <= RESP_OKAY;
            end else begin
              state  <= S_DATA;
              hready <= 1'b1;
              hresp  <= RESP_OKAY;
              if (!hwrite) begin
                hrdata <= rd_data;
              end
            end
          end else begin
            state  <= S_IDLE;
            hready <= 1'b1;
            hresp  <= RESP_OKAY;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state  <= S_DATA;
            hready <= 1'b1;
            hresp  <= RESP_OKAY;
            // No write can commit while in WAIT, so the array is current.
            if (!cur_write) begin
              hrdata <= mem[cur_index];
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state  <= S_ERR2;
          hready <= 1'b1;
          hresp  <= RESP_ERROR;
        end
        default: begin
          state  <= S_IDLE;
          hready <= 1'b1;
          hresp  <= RESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_interface.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_interface
//
// Three slave instances share the clock and reset:
//   dut 0: WAIT_STATES=1, dut 1: WAIT_STATES=0, dut 2: WAIT_STATES=15
// The driver pushes the expected per-cycle bus response into that instance's
// queue after each clock edge. The monitor pops the entry on the following
// falling edge and compares it against hready/hresp/hrdata.
// ---------------------------------------------------------------------------
module tb_ahb_slave_interface;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] OK       = 2'b00;
  localparam logic [1:0] ER       = 2'b01;

  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic        hclk;
  logic        hresetn;
  logic        sel   [3];
  logic [1:0]  trans [3];
  logic [31:0] addr  [3];
  logic        wr    [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        rdy   [3];
  logic [1:0]  resp  [3];

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  int checks = 0;
  int errors = 0;

  ahb_slave_interface #(.ADDR_BITS(4), .WAIT_STATES(1)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel[0]), .haddr(addr[0]),
    .hwrite(wr[0]), .htrans(trans[0]), .hwdata(wdata[0]),
    .hrdata(rdata[0]), .hready(rdy[0]), .hresp(resp[0])
  );

  ahb_slave_interface #(.ADDR_BITS(4), .WAIT_STATES(0)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel[1]), .haddr(addr[1]),
    .hwrite(wr[1]), .htrans(trans[1]), .hwdata(wdata[1]),
    .hrdata(rdata[1]), .hready(rdy[1]), .hresp(resp[1])
  );

  ahb_slave_interface #(.ADDR_BITS(4), .WAIT_STATES(15)) u_dut2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel[2]), .haddr(addr[2]),
    .hwrite(wr[2]), .htrans(trans[2]), .hwdata(wdata[2]),
    .hrdata(rdata[2]), .hready(rdy[2]), .hresp(resp[2])
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop(input int d, output exp_t e);
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // One bus cycle on instance d: present inputs, take the edge, then record
  // what the bus must show for the cycle that edge starts.
  task automatic cyc(input int d, input logic s, input logic [1:0] t,
                     input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic e_rdy, input logic [1:0] e_resp,
                     input logic e_chk, input logic [31:0] e_data);
    exp_t e;
    sel[d]   = s;
    trans[d] = t;
    addr[d]  = a;
    wr[d]    = w;
    wdata[d] = wd;
    @(posedge hclk);
    e.rdy  = e_rdy;
    e.resp = e_resp;
    e.chk  = e_chk;
    e.data = e_data;
    push(d, e);
    #1;
  endtask

  task automatic idle(input int d, input logic [31:0] wd, input logic e_rdy,
                      input logic [1:0] e_resp, input logic e_chk, input logic [31:0] e_data);
    cyc(d, 1'b0, T_IDLE, 32'h0, 1'b0, wd, e_rdy, e_resp, e_chk, e_data);
  endtask

  // Monitor
  always @(negedge hclk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (qsize(d) > 0) begin
        pop(d, e);
        check($sformatf("dut%0d hready", d), {31'b0, rdy[d]}, {31'b0, e.rdy});
        check($sformatf("dut%0d hresp", d), {30'b0, resp[d]}, {30'b0, e.resp});
        if (e.chk) begin
          check($sformatf("dut%0d hrdata", d), rdata[d], e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      sel[d]   = 1'b0;
      trans[d] = T_IDLE;
      addr[d]  = '0;
      wr[d]    = 1'b0;
      wdata[d] = '0;
    end
    hresetn = 1'b1;
    #2 hresetn = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d reset hready", d), {31'b0, rdy[d]}, 32'd1);
      check($sformatf("dut%0d reset hresp", d), {30'b0, resp[d]}, 32'd0);
      check($sformatf("dut%0d reset hrdata", d), rdata[d], 32'd0);
    end
    @(negedge hclk);
    hresetn = 1'b1;
    idle(0, 32'h0, 1'b1, OK, 1'b1, 32'h0);

    // Write 0xDEADBEEF to 0x8, pipelined read of 0x8 (one wait each)
    cyc(0, 1'b1, T_NONSEQ, 32'h8, 1'b1, 32'h0,         1'b0, OK, 1'b0, 32'h0);
    idle(0, 32'hDEADBEEF,                              1'b1, OK, 1'b0, 32'h0);
    cyc(0, 1'b1, T_NONSEQ, 32'h8, 1'b0, 32'hDEADBEEF,  1'b0, OK, 1'b0, 32'h0);
    idle(0, 32'h0,                                     1'b1, OK, 1'b1, 32'hDEADBEEF);
    idle(0, 32'h0,                                     1'b1, OK, 1'b1, 32'hDEADBEEF);

    // BUSY with hsel=1 and NONSEQ with hsel=0 must not write
    cyc(0, 1'b1, T_BUSY,   32'h8, 1'b1, 32'hFFFFFFFF,  1'b1, OK, 1'b0, 32'h0);
    cyc(0, 1'b0, T_NONSEQ, 32'h8, 1'b1, 32'hFFFFFFFF,  1'b1, OK, 1'b0, 32'h0);
    idle(0, 32'hFFFFFFFF,                              1'b1, OK, 1'b0, 32'h0);
    cyc(0, 1'b1, T_NONSEQ, 32'h8, 1'b0, 32'hFFFFFFFF,  1'b0, OK, 1'b0, 32'h0);
    idle(0, 32'hFFFFFFFF,                              1'b1, OK, 1'b1, 32'hDEADBEEF);
    idle(0, 32'h0,                                     1'b1, OK, 1'b0, 32'h0);

    // Out-of-range read, then pipelined in-range read of 0x0
    cyc(0, 1'b1, T_NONSEQ, 32'h100, 1'b0, 32'h0,       1'b0, ER, 1'b0, 32'h0);
    idle(0, 32'h0,                                     1'b1, ER, 1'b0, 32'h0);
    cyc(0, 1'b1, T_NONSEQ, 32'h0, 1'b0, 32'h0,         1'b0, OK, 1'b0, 32'h0);
    idle(0, 32'h0,                                     1'b1, OK, 1'b1, 32'h0);
    idle(0, 32'h0,                                     1'b1, OK, 1'b0, 32'h0);

    // Out-of-range write aliasing index 2 must leave 0x8 untouched
    cyc(0, 1'b1, T_NONSEQ, 32'h108, 1'b1, 32'h0,       1'b0, ER, 1'b0, 32'h0);
    idle(0, 32'h00000BAD,                              1'b1, ER, 1'b0, 32'h0);
    idle(0, 32'h00000BAD,                              1'b1, OK, 1'b0, 32'h0);
    cyc(0, 1'b1, T_NONSEQ, 32'h8, 1'b0, 32'h0,         1'b0, OK, 1'b0, 32'h0);
    idle(0, 32'h0,                                     1'b1, OK, 1'b1, 32'hDEADBEEF);
    idle(0, 32'h0,                                     1'b1, OK, 1'b0, 32'h0);

    // Zero waits: back-to-back write then read of 0x4 (forwarded)
    cyc(1, 1'b1, T_NONSEQ, 32'h4, 1'b1, 32'h0,         1'b1, OK, 1'b0, 32'h0);
    cyc(1, 1'b1, T_NONSEQ, 32'h4, 1'b0, 32'h12345678,  1'b1, OK, 1'b1, 32'h12345678);
    idle(1, 32'h0,                                     1'b1, OK, 1'b1, 32'h12345678);
    cyc(1, 1'b1, T_NONSEQ, 32'h4, 1'b0, 32'h0,         1'b1, OK, 1'b1, 32'h12345678);
    idle(1, 32'h0,                                     1'b1, OK, 1'b0, 32'h0);

    // Fifteen waits: write then read the top word (index 15)
    cyc(2, 1'b1, T_NONSEQ, 32'h3C, 1'b1, 32'hA5A55A5A, 1'b0, OK, 1'b0, 32'h0);
    for (int i = 0; i < 14; i++) idle(2, 32'hA5A55A5A, 1'b0, OK, 1'b0, 32'h0);
    idle(2, 32'hA5A55A5A,                              1'b1, OK, 1'b0, 32'h0);
    cyc(2, 1'b1, T_NONSEQ, 32'h3C, 1'b0, 32'hA5A55A5A, 1'b0, OK, 1'b0, 32'h0);
    for (int i = 0; i < 14; i++) idle(2, 32'h0, 1'b0, OK, 1'b0, 32'h0);
    idle(2, 32'h0,                                     1'b1, OK, 1'b1, 32'hA5A55A5A);
    idle(2, 32'h0,                                     1'b1, OK, 1'b1, 32'hA5A55A5A);

    // Reset in the middle of a WAIT cycle
    cyc(0, 1'b1, T_NONSEQ, 32'h8, 1'b0, 32'h0,         1'b0, OK, 1'b0, 32'h0);
    sel[0]   = 1'b0;
    trans[0] = T_IDLE;
    @(negedge hclk);
    #1 hresetn = 1'b0;
    #1;
    check("mid reset hready", {31'b0, rdy[0]}, 32'd1);
    check("mid reset hresp", {30'b0, resp[0]}, 32'd0);
    check("mid reset hrdata", rdata[0], 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    idle(0, 32'h0,                                     1'b1, OK, 1'b1, 32'h0);
    idle(0, 32'h0,                                     1'b1, OK, 1'b1, 32'h0);
    cyc(0, 1'b1, T_NONSEQ, 32'h8, 1'b0, 32'h0,         1'b0, OK, 1'b0, 32'h0);
    idle(0, 32'h0,                                     1'b1, OK, 1'b1, 32'h0);
    idle(0, 32'h0,                                     1'b1, OK, 1'b0, 32'h0);

    @(negedge hclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d queue drained", d), qsize(d), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_interface.md
# ahb_slave_interface

AHB slave-side interface that sits directly downstream of the master interface and address decoder. It samples the address-phase signals (haddr, hwrite, htrans, hwdata) when selected, inserts a configurable number of wait states, and serves reads and writes from an internal word-addressed register file. It drives hready/hresp/hrdata back to the master, including the two-cycle AHB ERROR response for out-of-range addresses.

## Interface
- ADDR_BITS, 4: register file depth is 2^ADDR_BITS 32-bit words.
- WAIT_STATES, 1: wait cycles inserted per OKAY transfer; legal range 0..15.
- hclk  input  1  bus clock; all state changes on its rising edge.
- hresetn  input  1  reset; asynchronous, active-low.
- hsel  input  1  slave select from the decoder.
- haddr  input  32  byte address from the master interface.
- hwrite  input  1  1 = write, 0 = read.
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwdata  input  32  write data, valid in the data phase.
- hrdata  output  32  read data to the master.
- hready  output  1  1 = current data phase completes this cycle.
- hresp  output  2  00 OKAY, 01 ERROR (RETRY/SPLIT never driven).

## Operation
- Transfer accepted at a rising edge where hready=1, hsel=1 and htrans is NONSEQ or SEQ. IDLE and BUSY, or hsel=0, are not accepted: no access, zero-wait OKAY.
- On acceptance, capture hwrite and index = haddr[ADDR_BITS+1:2]; haddr[1:0] ignored.
- Out of range: haddr[31:ADDR_BITS+2] != 0 -> ERROR response, no memory access.
- States:
  - IDLE: hready=1, hresp=OKAY.
  - WAIT: hready=0, hresp=OKAY; the wait counter counts down.
  - DATA: hready=1, hresp=OKAY; the completing cycle.
  - ERR1: hready=0, hresp=ERROR.
  - ERR2: hready=1, hresp=ERROR.
- Transitions out of IDLE, DATA and ERR2 (all hready=1 states):
  - Accepted in range with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - Accepted in range with WAIT_STATES=0 -> DATA.
  - Accepted out of range -> ERR1.
  - Otherwise -> IDLE.
- WAIT -> DATA when the counter reaches 0; otherwise decrement. ERR1 -> ERR2 unconditionally.
- Write: hwdata is sampled at the edge leaving DATA and written to mem[index].
- Read: hrdata is loaded with mem[index] at the edge entering DATA. hrdata holds its last value in all other states.
- Forwarding: if a read enters DATA on the same edge a write to the same index commits, hrdata takes that edge's hwdata.
- Pipelining: a new transfer may be accepted on the same edge the previous one completes (DATA/ERR2), so back-to-back transfers carry no idle gap.

## Timing
- Reset (async, any state, mid-transfer included):
  - State goes to IDLE.
  - hready=1, hresp=00, hrdata=0.
  - All register-file words go to 0; the wait counter goes to 0.
  - Any pending write is dropped.
- Transfer length, address-phase edge to completion, is WAIT_STATES+1 cycles for OKAY and 2 cycles for ERROR.
- hready, hresp and hrdata are registered outputs; no combinational path from inputs.
- During WAIT and ERR1, inputs are ignored for acceptance (hready=0 means no new address phase).

## Test plan
- Reset then idle: hresetn low mid-WAIT -> immediately hready=1, hresp=00, hrdata=0; after release with htrans=IDLE, hready stays 1.
- Write/read, WAIT_STATES=1: write 0xDEADBEEF to 0x8, then read 0x8 -> each transfer shows 1 cycle hready=0 then hready=1; the read returns hrdata=0xDEADBEEF, hresp=00.
- Back-to-back, WAIT_STATES=0: NONSEQ write 0x12345678 to 0x4 followed immediately by a read of 0x4 -> read data phase returns 0x12345678 (forwarding); no hready=0 cycles.
- Out of range: read 0x0000_0100 with ADDR_BITS=4 -> ERR1 (hready=0, hresp=01), then ERR2 (hready=1, hresp=01); memory unchanged; the next read of 0x0 returns OKAY.
- BUSY/unselected: htrans=BUSY with hsel=1, and NONSEQ with hsel=0, write 0xFFFFFFFF -> hready=1, hresp=00, no write; a subsequent read returns the prior value.
- Max waits: WAIT_STATES=15 read -> exactly 15 cycles hready=0, then 1 cycle hready=1 with correct data.
